// File: rtl/id_ex_stage.sv
// ID/EX pipeline register.
// Captures register-bank operands and decode fields into the EX stage.
// Detects load-use hazards against the load currently in EX. On a hazard it
// raises stall so the front end holds, and it inserts a bubble into EX.
// Inserted bubbles are counted by a saturating counter.
//
// Valid semantics: ex_valid marks a real instruction in EX. Whenever ex_valid
// is 0, every control output (reg_write, mem_read, mem_write, mem_to_reg,
// reg_dst, alu_src, alu_op, uses_rt) is 0, so a bubble has no side effects
// downstream. There is no backpressure from EX: each posedge either loads the
// ID instruction or inserts a bubble. On a hazard the ID instruction stays in
// IF/ID, because stall holds it there, and it is presented again next cycle.
module id_ex_stage #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               id_valid,
    input  logic [DATA_W-1:0]  id_busA,
    input  logic [DATA_W-1:0]  id_busB,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic [DATA_W-1:0]  id_pc4,
    input  logic [REG_AW-1:0]  id_rs,
    input  logic [REG_AW-1:0]  id_rt,
    input  logic [REG_AW-1:0]  id_rd,
    input  logic               id_uses_rt,
    input  logic               id_reg_write,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic               id_mem_to_reg,
    input  logic               id_reg_dst,
    input  logic               id_alu_src,
    input  logic [ALUOP_W-1:0] id_alu_op,
    output logic               ex_valid,
    output logic [DATA_W-1:0]  ex_busA,
    output logic [DATA_W-1:0]  ex_busB,
    output logic [DATA_W-1:0]  ex_imm,
    output logic [DATA_W-1:0]  ex_pc4,
    output logic [REG_AW-1:0]  ex_rs,
    output logic [REG_AW-1:0]  ex_rt,
    output logic [REG_AW-1:0]  ex_rd,
    output logic               ex_uses_rt,
    output logic               ex_reg_write,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               ex_mem_to_reg,
    output logic               ex_reg_dst,
    output logic               ex_alu_src,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic [REG_AW-1:0]  ex_dest,
    output logic               stall,
    output logic [CNT_W-1:0]   bubble_cnt
);

    // EX-stage registers and their next-state values
    logic               valid_q,      valid_d;
    logic [DATA_W-1:0]  busA_q,       busA_d;
    logic [DATA_W-1:0]  busB_q,       busB_d;
    logic [DATA_W-1:0]  imm_q,        imm_d;
    logic [DATA_W-1:0]  pc4_q,        pc4_d;
    logic [REG_AW-1:0]  rs_q,         rs_d;
    logic [REG_AW-1:0]  rt_q,         rt_d;
    logic [REG_AW-1:0]  rd_q,         rd_d;
    logic [REG_AW-1:0]  dest_q,       dest_d;
    logic               uses_rt_q,    uses_rt_d;
    logic               reg_write_q,  reg_write_d;
    logic               mem_read_q,   mem_read_d;
    logic               mem_write_q,  mem_write_d;
    logic               mem_to_reg_q, mem_to_reg_d;
    logic               reg_dst_q,    reg_dst_d;
    logic               alu_src_q,    alu_src_d;
    logic [ALUOP_W-1:0] alu_op_q,     alu_op_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;

    logic haz;
    logic rt_match;
    logic rs_match;
    logic load_id;

    // Load-use hazard: the load in EX writes a register that ID reads.
    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    always_comb begin
        rs_match = (rt_q == id_rs);
        rt_match = id_uses_rt & (rt_q == id_rt);
        haz      = valid_q & mem_read_q & (rt_q != '0) & id_valid & (rs_match | rt_match);
        // Flush kills the ID instruction anyway, so holding the front end would be pointless.
        stall    = haz & ~flush;
        load_id  = ~flush & ~haz;
    end

    // Next EX contents: flush and hazard both yield an all-zero bubble; otherwise take ID.
    always_comb begin
        valid_d      = 1'b0;
        busA_d       = '0;
        busB_d       = '0;
        imm_d        = '0;
        pc4_d        = '0;
        rs_d         = '0;
        rt_d         = '0;
        rd_d         = '0;
        dest_d       = '0;
        uses_rt_d    = 1'b0;
        reg_write_d  = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        reg_dst_d    = 1'b0;
        alu_src_d    = 1'b0;
        alu_op_d     = '0;
        if (load_id) begin
            valid_d = id_valid;
            busA_d  = id_busA;
            busB_d  = id_busB;
            imm_d   = id_imm;
            pc4_d   = id_pc4;
            rs_d    = id_rs;
            rt_d    = id_rt;
            rd_d    = id_rd;
            dest_d  = id_reg_dst ? id_rd : id_rt;
            // Controls of a non-instruction are dropped so later stages see no side effects.
            if (id_valid) begin
                uses_rt_d    = id_uses_rt;
                reg_write_d  = id_reg_write;
                mem_read_d   = id_mem_read;
                mem_write_d  = id_mem_write;
                mem_to_reg_d = id_mem_to_reg;
                reg_dst_d    = id_reg_dst;
                alu_src_d    = id_alu_src;
                alu_op_d     = id_alu_op;
            end
        end
    end

    // Bubble counter: counts hazard bubbles only, never flush bubbles; saturates at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (~flush && haz && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // EX register bank with asynchronous clear; reset discards the in-flight instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            busA_q       <= '0;
            busB_q       <= '0;
            imm_q        <= '0;
            pc4_q        <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
            dest_q       <= '0;
            uses_rt_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            reg_dst_q    <= 1'b0;
            alu_src_q    <= 1'b0;
            alu_op_q     <= '0;
            cnt_q        <= '0;
        end else begin
            valid_q      <= valid_d;
            busA_q       <= busA_d;
            busB_q       <= busB_d;
            imm_q        <= imm_d;
            pc4_q        <= pc4_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            rd_q         <= rd_d;
            dest_q       <= dest_d;
            uses_rt_q    <= uses_rt_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            reg_dst_q    <= reg_dst_d;
            alu_src_q    <= alu_src_d;
            alu_op_q     <= alu_op_d;
            cnt_q        <= cnt_d;
        end
    end

    // Drive the EX-facing outputs straight from the registers.
    always_comb begin
        ex_valid      = valid_q;
        ex_busA       = busA_q;
        ex_busB       = busB_q;
        ex_imm        = imm_q;
        ex_pc4        = pc4_q;
        ex_rs         = rs_q;
        ex_rt         = rt_q;
        ex_rd         = rd_q;
        ex_dest       = dest_q;
        ex_uses_rt    = uses_rt_q;
        ex_reg_write  = reg_write_q;
        ex_mem_read   = mem_read_q;
        ex_mem_write  = mem_write_q;
        ex_mem_to_reg = mem_to_reg_q;
        ex_reg_dst    = reg_dst_q;
        ex_alu_src    = alu_src_q;
        ex_alu_op     = alu_op_q;
        bubble_cnt    = cnt_q;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed load-use/flush/saturation scenarios followed by
// randomized instruction streams, all checked against a behavioural model of EX.
module tb_id_ex_stage;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int OW = 4;
  localparam int CW = 2;

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] busA;
    logic [DW-1:0] busB;
    logic [DW-1:0] imm;
    logic [DW-1:0] pc4;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] rd;
    logic          uses_rt;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          mem_to_reg;
    logic          reg_dst;
    logic          alu_src;
    logic [OW-1:0] alu_op;
  } id_t;

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] busA;
    logic [DW-1:0] busB;
    logic [DW-1:0] imm;
    logic [DW-1:0] pc4;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] rd;
    logic [AW-1:0] dest;
    logic          uses_rt;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          mem_to_reg;
    logic          reg_dst;
    logic          alu_src;
    logic [OW-1:0] alu_op;
  } ex_t;

  localparam int W = $bits(ex_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          flush, id_valid, id_uses_rt, id_reg_write, id_mem_read, id_mem_write;
  logic          id_mem_to_reg, id_reg_dst, id_alu_src;
  logic [DW-1:0] id_busA, id_busB, id_imm, id_pc4;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic [OW-1:0] id_alu_op;
  logic          ex_valid, ex_uses_rt, ex_reg_write, ex_mem_read, ex_mem_write;
  logic          ex_mem_to_reg, ex_reg_dst, ex_alu_src, stall;
  logic [DW-1:0] ex_busA, ex_busB, ex_imm, ex_pc4;
  logic [AW-1:0] ex_rs, ex_rt, ex_rd, ex_dest;
  logic [OW-1:0] ex_alu_op;
  logic [CW-1:0] bubble_cnt;

  id_ex_stage #(.DATA_W(DW), .REG_AW(AW), .ALUOP_W(OW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid(id_valid), .id_busA(id_busA), .id_busB(id_busB), .id_imm(id_imm),
    .id_pc4(id_pc4), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg), .id_reg_dst(id_reg_dst),
    .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
    .ex_valid(ex_valid), .ex_busA(ex_busA), .ex_busB(ex_busB), .ex_imm(ex_imm),
    .ex_pc4(ex_pc4), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_uses_rt(ex_uses_rt), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_dst(ex_reg_dst),
    .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op), .ex_dest(ex_dest),
    .stall(stall), .bubble_cnt(bubble_cnt)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  ex_t m_ex;            // model of the instruction sitting in EX
  int  m_cnt;           // model bubble count (plain integer, clamped)
  logic last_stall;

  task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic ex_t dut_ex();
    ex_t e;
    e.valid = ex_valid;   e.busA = ex_busA;   e.busB = ex_busB;   e.imm = ex_imm;
    e.pc4 = ex_pc4;       e.rs = ex_rs;       e.rt = ex_rt;       e.rd = ex_rd;
    e.dest = ex_dest;     e.uses_rt = ex_uses_rt;                 e.reg_write = ex_reg_write;
    e.mem_read = ex_mem_read;   e.mem_write = ex_mem_write;       e.mem_to_reg = ex_mem_to_reg;
    e.reg_dst = ex_reg_dst;     e.alu_src = ex_alu_src;           e.alu_op = ex_alu_op;
    return e;
  endfunction

  // A load in EX blocks any ID instruction that reads its destination (never $zero).
  function automatic logic model_hazard(input id_t d);
    logic reads_it;
    reads_it = (d.rs == m_ex.rt) || (d.uses_rt && d.rt == m_ex.rt);
    return m_ex.valid && m_ex.mem_read && m_ex.rt != 0 && d.valid && reads_it;
  endfunction

  // What EX should hold after the edge: a zeroed bubble, or the ID instruction.
  function automatic ex_t model_next(input id_t d, input logic fl, input logic hz);
    ex_t n = '0;
    if (!fl && !hz) begin
      n.valid = d.valid; n.busA = d.busA; n.busB = d.busB; n.imm = d.imm; n.pc4 = d.pc4;
      n.rs = d.rs; n.rt = d.rt; n.rd = d.rd;
      n.dest = d.reg_dst ? d.rd : d.rt;
      if (d.valid) begin
        n.uses_rt = d.uses_rt; n.reg_write = d.reg_write; n.mem_read = d.mem_read;
        n.mem_write = d.mem_write; n.mem_to_reg = d.mem_to_reg; n.reg_dst = d.reg_dst;
        n.alu_src = d.alu_src; n.alu_op = d.alu_op;
      end
    end
    return n;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input id_t d, input logic fl);
    flush = fl;
    id_valid = d.valid; id_busA = d.busA; id_busB = d.busB; id_imm = d.imm; id_pc4 = d.pc4;
    id_rs = d.rs; id_rt = d.rt; id_rd = d.rd; id_uses_rt = d.uses_rt;
    id_reg_write = d.reg_write; id_mem_read = d.mem_read; id_mem_write = d.mem_write;
    id_mem_to_reg = d.mem_to_reg; id_reg_dst = d.reg_dst; id_alu_src = d.alu_src;
    id_alu_op = d.alu_op;
  endtask

  // One pipeline cycle: present ID, check stall, clock, check EX and counter.
  task automatic cycle(input id_t d, input logic fl);
    logic hz;
    drive(d, fl);
    #1;
    hz = model_hazard(d);
    last_stall = hz && !fl;
    check_val("stall", W'(stall), W'(last_stall));
    exp_q.push_back(model_next(d, fl, hz));
    if (hz && !fl && m_cnt < (1 << CW) - 1) m_cnt++;
    m_ex = model_next(d, fl, hz);
    @(posedge clk);
    #1;
    check_val("ex_state", dut_ex(), exp_q.pop_front());
    check_val("bubble_cnt", W'(bubble_cnt), W'(m_cnt));
  endtask

  function automatic id_t r_type(input int rs, input int rt, input int rd, input int a, input int b);
    id_t d = '0;
    d.valid = 1; d.rs = AW'(rs); d.rt = AW'(rt); d.rd = AW'(rd);
    d.busA = DW'(a); d.busB = DW'(b); d.pc4 = 32'h100;
    d.uses_rt = 1; d.reg_write = 1; d.reg_dst = 1; d.alu_op = 4'h2;
    return d;
  endfunction

  function automatic id_t lw(input int rs, input int rt, input int imm);
    id_t d = '0;
    d.valid = 1; d.rs = AW'(rs); d.rt = AW'(rt); d.rd = 5'd9; d.imm = DW'(imm); d.pc4 = 32'h200;
    d.reg_write = 1; d.mem_read = 1; d.mem_to_reg = 1; d.alu_src = 1; d.alu_op = 4'h2;
    return d;
  endfunction

  function automatic id_t addi(input int rs, input int rt, input int imm);
    id_t d = '0;
    d.valid = 1; d.rs = AW'(rs); d.rt = AW'(rt); d.imm = DW'(imm); d.pc4 = 32'h300;
    d.reg_write = 1; d.alu_src = 1; d.alu_op = 4'h2;
    return d;
  endfunction

  function automatic id_t sw(input int rs, input int rt);
    id_t d = '0;
    d.valid = 1; d.rs = AW'(rs); d.rt = AW'(rt); d.pc4 = 32'h400;
    d.uses_rt = 1; d.mem_write = 1; d.alu_src = 1; d.alu_op = 4'h2;
    return d;
  endfunction

  function automatic id_t rand_id();
    id_t d;
    int kind;
    kind = $urandom_range(0, 5);
    case (kind)
      0, 1: d = r_type($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 31),
                       $urandom, $urandom);
      2, 3: d = lw($urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      4:    d = sw($urandom_range(0, 3), $urandom_range(0, 3));
      default: begin
        d = id_t'({$urandom, $urandom, $urandom, $urandom, $urandom});
        d.valid = ($urandom_range(0, 1) == 1);
        d.rs = AW'($urandom_range(0, 3));
        d.rt = AW'($urandom_range(0, 3));
      end
    endcase
    d.busB = $urandom;
    d.pc4 = $urandom;
    return d;
  endfunction

  task automatic run_random(input int n);
    id_t cur;
    cur = rand_id();
    for (int i = 0; i < n; i++) begin
      cycle(cur, ($urandom_range(0, 9) == 0));
      if (!last_stall) cur = rand_id();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    m_ex = '0;
    m_cnt = 0;
    last_stall = 0;
    drive('0, 1'b0);
    #1;
    check_val("reset_ex", dut_ex(), '0);
    check_val("reset_cnt", W'(bubble_cnt), '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // ADD r3,r1,r2 with busA=5, busB=7
    cycle(r_type(1, 2, 3, 5, 7), 1'b0);
    check_val("add_busA", W'(ex_busA), W'(5));
    check_val("add_busB", W'(ex_busB), W'(7));
    check_val("add_dest", W'(ex_dest), W'(3));
    check_val("add_regwrite", W'(ex_reg_write), W'(1));

    // LW r4 then dependent ADD r5,r4,r1: one bubble, then the ADD passes
    cycle(lw(1, 4, 16), 1'b0);
    cycle(r_type(4, 1, 5, 11, 22), 1'b0);
    check_val("lu_stall", W'(last_stall), W'(1));
    check_val("lu_bubble", W'(ex_valid), W'(0));
    check_val("lu_cnt", W'(bubble_cnt), W'(1));
    cycle(r_type(4, 1, 5, 11, 22), 1'b0);
    check_val("lu_pass_valid", W'(ex_valid), W'(1));
    check_val("lu_pass_dest", W'(ex_dest), W'(5));

    // No hazard: ADDI r4,r0 after LW r4; dependency on $zero
    cycle(lw(1, 4, 8), 1'b0);
    cycle(addi(0, 4, 99), 1'b0);
    check_val("addi_nohaz", W'(ex_valid), W'(1));
    cycle(lw(2, 0, 4), 1'b0);
    cycle(r_type(0, 3, 6, 1, 2), 1'b0);
    check_val("zero_nohaz", W'(ex_valid), W'(1));

    // Flush coincident with hazard, then flush alone on a store
    cycle(lw(1, 4, 8), 1'b0);
    cycle(r_type(4, 2, 7, 3, 4), 1'b1);
    check_val("flush_haz_valid", W'(ex_valid), W'(0));
    check_val("flush_haz_cnt", W'(bubble_cnt), W'(1));
    cycle(sw(1, 2), 1'b1);
    check_val("flush_regwrite", W'(ex_reg_write), W'(0));
    check_val("flush_memwrite", W'(ex_mem_write), W'(0));

    // Counter saturation with a 2-bit counter
    for (int i = 0; i < 3; i++) begin
      cycle(lw(1, 4, 8), 1'b0);
      cycle(r_type(4, 4, 5, 1, 1), 1'b0);
      cycle(r_type(4, 4, 5, 1, 1), 1'b0);
    end
    check_val("sat_cnt", W'(bubble_cnt), W'(3));
    cycle(lw(1, 4, 8), 1'b0);
    cycle(r_type(4, 4, 5, 1, 1), 1'b0);
    check_val("sat_nowrap", W'(bubble_cnt), W'(3));

    // Randomized streams
    run_random(400);

    // Asynchronous reset mid-stream with a live instruction in EX
    cycle(r_type(1, 2, 3, 5, 7), 1'b0);
    check_val("pre_rst_valid", W'(ex_valid), W'(1));
    #2;
    rst = 1'b1;
    #1;
    m_ex = '0;
    m_cnt = 0;
    check_val("async_rst_ex", dut_ex(), '0);
    check_val("async_rst_cnt", W'(bubble_cnt), '0);
    @(posedge clk);
    #1;
    check_val("rst_hold_ex", dut_ex(), '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_random(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
